// File: rtl/mem_arbiter_if.sv
// Request/response bundle around the shared memory arbiter: IFU and LSU requester
// channels plus the single memory port. The master modport is the arbiter's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_resp_data;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_resp_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport master (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store,
// with a single outstanding transaction and response routing by owner.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus
);
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t            state;
  logic              owner;       // 0 = IFU, 1 = LSU
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic grant_lsu;
  logic take_ifu;
  logic take_lsu;
  logic resp_hit;

  // On a tie the side that was not served last wins.
  always_comb begin
    grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_grant);
    take_lsu  = (state == IDLE) && grant_lsu;
    take_ifu  = (state == IDLE) && bus.ifu_req_valid && !grant_lsu;
    resp_hit  = (state == WAIT) && bus.mem_resp_valid;
  end

  assign bus.ifu_req_ready  = take_ifu;
  assign bus.lsu_req_ready  = take_lsu;
  assign bus.ifu_resp_valid = resp_hit && !owner;
  assign bus.lsu_resp_valid = resp_hit && owner;
  assign bus.ifu_resp_data  = bus.mem_resp_data;
  assign bus.lsu_resp_data  = bus.mem_resp_data;

  assign bus.mem_req_valid  = (state == REQ);
  assign bus.mem_req_addr   = addr_q;
  assign bus.mem_req_wen    = wen_q;
  assign bus.mem_req_wdata  = wdata_q;
  assign bus.mem_req_wmask  = wmask_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_lsu) begin
            addr_q  <= bus.lsu_req_addr;
            wen_q   <= bus.lsu_req_wen;
            wdata_q <= bus.lsu_req_wdata;
            wmask_q <= bus.lsu_req_wmask;
            owner   <= 1'b1;
            state   <= REQ;
          end else if (take_ifu) begin
            addr_q  <= bus.ifu_req_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            owner   <= 1'b0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single NPC memory port between instruction fetch (IFU) and load/store (LSU). It accepts one request at a time over a valid/ready handshake and issues it to the memory port. It waits for the single response and routes that response back to the requester that owns it. It sits between the fetch/LSU stages and the DPI-backed memory model. This replaces the direct pmem access from the fetch stage once loads and stores share the same port.

## Interface
- ADDR_W, 64, request address width
- DATA_W, 64, data width; write mask width is DATA_W/8
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ifu_req_valid  in  1  fetch request present
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address, 8-byte aligned
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_resp_data  out  DATA_W  fetch data
- lsu_req_valid  in  1  load/store request present
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_req_addr  in  ADDR_W  load/store address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DATA_W  store data
- lsu_req_wmask  in  DATA_W/8  store byte mask
- lsu_resp_valid  out  1  one-cycle pulse, load data valid or store complete
- lsu_resp_data  out  DATA_W  load data (don't-care for stores)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  latched request fields
- mem_resp_valid  in  1  memory response
- mem_resp_data  in  DATA_W  memory read data

## Operation
- The FSM has three states: IDLE, REQ and WAIT. It also keeps an owner register (0 = IFU, 1 = LSU) and a last_grant register.
- IDLE:
  - Only one requester has valid asserted: grant that requester.
  - Both requesters have valid asserted: grant the one that is not last_grant (round-robin).
  - The granted side's req_ready is asserted combinationally; the other side's req_ready stays 0.
  - On handshake: latch addr, wen, wdata and wmask; set owner; go to REQ.
  - IFU requests are latched with wen=0 and wmask=0.
- REQ:
  - mem_req_valid=1, with latched fields held stable.
  - When mem_req_ready=1: go to WAIT.
  - Both req_ready outputs are 0.
- WAIT:
  - mem_req_valid=0.
  - When mem_resp_valid=1:
    - Pulse the owner's resp_valid in the same cycle (combinational pass-through).
    - Drive mem_resp_data onto both resp_data outputs.
    - Set last_grant=owner and go to IDLE.
- Only one transaction is outstanding at any time. No new request is accepted until the response has returned.
- mem_resp_valid in IDLE or REQ is a protocol error: it is ignored and produces no resp_valid.
- A requester may drop valid before it is granted; no state changes.
- Reset values:
  - state=IDLE, owner=0, last_grant=1, so the first tie goes to the IFU.
  - All latched request fields are 0.
  - All valid/ready outputs are 0 in the cycle after reset deasserts, except the combinational req_ready in IDLE.
- Reset mid-transaction: return to IDLE and drop the transaction. A late mem_resp_valid is ignored.

## Timing
- Handshake at cycle T means state is IDLE and valid & ready=1.
- mem_req_valid rises at T+1.
- If mem_req_ready=1 at T+1, the FSM is in WAIT at T+2.
- Earliest resp_valid is at T+2, in the same cycle as mem_resp_valid.
- The FSM is in IDLE again at T+3, which is the earliest next handshake.
- Minimum request-to-request spacing is 3 cycles. Each additional memory stall cycle in REQ or WAIT adds 1 cycle.
- resp_valid is high for exactly the cycles in which mem_resp_valid is high in WAIT. This is at most one cycle per transaction, since WAIT exits on the first response.
- mem_req_* fields are constant from T+1 until the cycle in which mem_req_ready is sampled high.

## Test plan
- IFU-only fetch:
  - Stimulus: ifu_req_addr=0x80000000, memory ready and response immediate with data 0x00000013_00100093.
  - Required: ifu_req_ready=1 at T, mem_req_addr=0x80000000 with wen=0 at T+1, ifu_resp_valid=1 with that data at T+2, lsu_resp_valid=0 throughout.
- LSU store:
  - Stimulus: addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, wen=1.
  - Required: mem_req carries exactly those fields, lsu_resp_valid pulses once, ifu_resp_valid stays 0.
- Simultaneous requests held valid for 4 transactions:
  - Required grant order is IFU, LSU, IFU, LSU.
  - Each response is routed to the matching owner.
- Memory stalls:
  - Stimulus: mem_req_ready=0 for 3 cycles, then response delayed 2 cycles.
  - Required: mem_req fields stable across the stall, both req_ready=0 for the whole transaction, a single resp_valid pulse at the 5th cycle after entering REQ.
- Reset while in WAIT:
  - Stimulus: assert reset while in WAIT, then raise mem_resp_valid one cycle after reset deasserts.
  - Required: FSM in IDLE, no resp_valid pulse, and the next IFU request is served normally.
- Spurious response:
  - Stimulus: mem_resp_valid=1 while in IDLE.
  - Required: no resp_valid on either requester; state unchanged.
